mm_weight_loader: RTL and testbench

MM_WEIGHT_LOADER -- requirements
Module: mm_weight_loader

---
 rtl/mm_pkg.sv | 18 +
 rtl/mm_weight_loader.sv | 186 ++++++++++++++++++
 tb/tb_mm_weight_loader.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared constants and FSM state type for the matrix-multiply weight loader.
// Contents: beat/row/address widths, default packing factor, loader state enum.
package mm_pkg;

  localparam int unsigned BEAT_W        = 512;
  localparam int unsigned BEATS_PER_ROW = 16;
  localparam int unsigned ROW_W         = BEAT_W * BEATS_PER_ROW;
  localparam int unsigned WADDR_W       = 13;
  localparam int unsigned STALL_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } wl_state_e;

endpackage

// File: rtl/mm_weight_loader.sv
// mm_weight_loader: packs streamed 512-bit beats into wide weight rows and
// writes each completed row into the weight buffer at consecutive addresses.
//
// Ports
//   clk, rstn                       clock, async active-low reset
//   start_valid                     one-cycle load request (honoured in IDLE only)
//   weight_start_addr, row_count    first row address and row count, sampled at start
//   s_data, s_valid, s_ready        beat stream; transfer on s_valid & s_ready
//   weight_wr_en/addr/data          one-cycle row write to the weight buffer
//   busy                            job in progress (LOAD, WRITE, FIN)
//   done                            one-cycle completion pulse
//   stall_cycles                    LOAD cycles without a valid beat (optional)
//
// Build option: define MM_WLOAD_STALL_CNT_EN to add the stall_cycles output.
module mm_weight_loader #(
  parameter int unsigned BEATS_PER_ROW = mm_pkg::BEATS_PER_ROW,
  parameter int unsigned ADDR_W        = mm_pkg::WADDR_W
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     start_valid,
  input  logic [ADDR_W-1:0]                        weight_start_addr,
  input  logic [ADDR_W-1:0]                        row_count,
  input  logic [mm_pkg::BEAT_W-1:0]                s_data,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  output logic                                     weight_wr_en,
  output logic [ADDR_W-1:0]                        weight_wr_addr,
  output logic [mm_pkg::BEAT_W*BEATS_PER_ROW-1:0]  weight_wr_data,
  output logic                                     busy,
  output logic                                     done
`ifdef MM_WLOAD_STALL_CNT_EN
  ,
  output logic [mm_pkg::STALL_W-1:0]               stall_cycles
`endif
);

  import mm_pkg::*;

  localparam int unsigned ROW_BITS = BEAT_W * BEATS_PER_ROW;
  localparam int unsigned CNT_W    = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_ROW - 1);

  wl_state_e             state_q, state_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]     row_idx_q, row_idx_d;
  logic [ADDR_W-1:0]     rows_q, rows_d;
  logic [ADDR_W-1:0]     start_addr_q, start_addr_d;
  logic [ROW_BITS-1:0]   row_buf_q, row_buf_d;
  logic [ROW_BITS-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic                  s_ready_q, s_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  beat_xfer_c;
  logic                  last_row_c;
`ifdef MM_WLOAD_STALL_CNT_EN
  logic [STALL_W-1:0]    stall_q, stall_d;
`endif

  // s_ready_q is high exactly while the FSM sits in LOAD
  assign beat_xfer_c = s_ready_q & s_valid;
  assign last_row_c  = (ADDR_W'(row_idx_q + 1'b1) == rows_q);

  // Next-state, beat packing and registered-output decode
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    row_idx_d    = row_idx_q;
    rows_d       = rows_q;
    start_addr_d = start_addr_q;
    row_buf_d    = row_buf_q;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;
`ifdef MM_WLOAD_STALL_CNT_EN
    stall_d      = stall_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          start_addr_d = weight_start_addr;
          rows_d       = row_count;
          beat_cnt_d   = '0;
          row_idx_d    = '0;
`ifdef MM_WLOAD_STALL_CNT_EN
          stall_d      = '0;
`endif
          state_d      = (row_count == '0) ? FIN : LOAD;
        end
      end

      LOAD: begin
        if (beat_xfer_c) begin
          for (int unsigned k = 0; k < BEATS_PER_ROW; k++) begin
            if (beat_cnt_q == CNT_W'(k)) begin
              row_buf_d[k*BEAT_W +: BEAT_W] = s_data;
            end
          end
          if (beat_cnt_q == LAST_BEAT) begin
            // Output row register captures the full row including the final beat
            wr_data_d  = row_buf_d;
            wr_addr_d  = ADDR_W'(start_addr_q + row_idx_q);
            beat_cnt_d = '0;
            state_d    = WRITE;
          end else begin
            beat_cnt_d = CNT_W'(beat_cnt_q + 1'b1);
          end
        end
`ifdef MM_WLOAD_STALL_CNT_EN
        else if (!s_valid && (stall_q != '1)) begin
          stall_d = STALL_W'(stall_q + 1'b1);
        end
`endif
      end

      WRITE: begin
        row_idx_d = ADDR_W'(row_idx_q + 1'b1);
        state_d   = last_row_c ? FIN : LOAD;
      end

      FIN: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == LOAD);
    wr_en_d   = (state_d == WRITE);
    done_d    = (state_d == FIN);
    busy_d    = (state_d != IDLE);
  end

  // Control state, counters and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      row_idx_q    <= '0;
      rows_q       <= '0;
      start_addr_q <= '0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef MM_WLOAD_STALL_CNT_EN
      stall_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      row_idx_q    <= row_idx_d;
      rows_q       <= rows_d;
      start_addr_q <= start_addr_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      wr_en_q      <= wr_en_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef MM_WLOAD_STALL_CNT_EN
      stall_q      <= stall_d;
`endif
    end
  end

  // Beat staging buffer: pure datapath, every slice is rewritten before use
  always_ff @(posedge clk) begin
    row_buf_q <= row_buf_d;
  end

  assign s_ready        = s_ready_q;
  assign weight_wr_en   = wr_en_q;
  assign weight_wr_addr = wr_addr_q;
  assign weight_wr_data = wr_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
`ifdef MM_WLOAD_STALL_CNT_EN
  assign stall_cycles   = stall_q;
`endif

endmodule

// File: tb/tb_mm_weight_loader.sv
// Self-checking bench for mm_weight_loader: a scoreboard of expected row
// writes is filled when a job is issued and drained by a write monitor.
module tb_mm_weight_loader;

  localparam int unsigned BW = 512;
  localparam int unsigned NB = 16;
  localparam int unsigned RW = BW * NB;
  localparam int unsigned AW = 13;

  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic           start_valid = 1'b0;
  logic [AW-1:0]  weight_start_addr = '0;
  logic [AW-1:0]  row_count = '0;
  logic [BW-1:0]  s_data = '0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic           weight_wr_en;
  logic [AW-1:0]  weight_wr_addr;
  logic [RW-1:0]  weight_wr_data;
  logic           busy;
  logic           done;
`ifdef MM_WLOAD_STALL_CNT_EN
  logic [15:0]    stall_cycles;
`endif

  mm_weight_loader #(.BEATS_PER_ROW(NB), .ADDR_W(AW)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .start_valid       (start_valid),
    .weight_start_addr (weight_start_addr),
    .row_count         (row_count),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .weight_wr_en      (weight_wr_en),
    .weight_wr_addr    (weight_wr_addr),
    .weight_wr_data    (weight_wr_data),
    .busy              (busy),
    .done              (done)
`ifdef MM_WLOAD_STALL_CNT_EN
    ,
    .stall_cycles      (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
  } wr_exp_t;

  wr_exp_t       exp_q[$];
  wr_exp_t       mon_e;
  int            tests_run = 0;
  int            tests_failed = 0;
  int            cyc = 0;
  int            wr_cnt = 0;
  int            done_cnt = 0;
  int            ready_cnt = 0;
  int            last_wr_cyc = -1;
  bit            hold_ok = 1'b0;
  logic [RW-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Beat i carries the 32-bit index i replicated across the beat
  function automatic logic [BW-1:0] beat(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {16{v}};
  endfunction

  function automatic logic [RW-1:0] row_of(input int first);
    logic [RW-1:0] r;
    for (int k = 0; k < int'(NB); k++) r[k*BW +: BW] = beat(first + k);
    return r;
  endfunction

  function automatic void push_exp(input logic [AW-1:0] a, input int first);
    wr_exp_t e;
    e.addr = a;
    e.data = row_of(first);
    exp_q.push_back(e);
  endfunction

  // Write monitor: scoreboard pop on every write, data hold check otherwise
  always @(negedge clk) begin
    if (!rstn) begin
      hold_ok = 1'b0;
    end else begin
      if (s_ready) ready_cnt++;
      if (done) done_cnt++;
      if (weight_wr_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected_write: got write at addr=%h, required no write", weight_wr_addr);
        end else begin
          mon_e = exp_q.pop_front();
          if (weight_wr_addr !== mon_e.addr || weight_wr_data !== mon_e.data) begin
            tests_failed++;
            $display("FAIL sb_row_write: got addr=%h data[63:0]=%h, required addr=%h data[63:0]=%h",
                     weight_wr_addr, weight_wr_data[63:0], mon_e.addr, mon_e.data[63:0]);
          end
        end
      end else if (hold_ok) begin
        tests_run++;
        if (weight_wr_data !== prev_data) begin
          tests_failed++;
          $display("FAIL wr_data_hold: got data[63:0]=%h, required %h", weight_wr_data[63:0], prev_data[63:0]);
        end
      end
      hold_ok = 1'b1;
    end
    prev_data = weight_wr_data;
  end

  // Issue a start in the current cycle; sc is the first cycle after it
  task automatic start_job(input logic [AW-1:0] a, input logic [AW-1:0] n, output int sc);
    start_valid       = 1'b1;
    weight_start_addr = a;
    row_count         = n;
    @(posedge clk); #1;
    start_valid = 1'b0;
    sc = cyc;
  endtask

  // Stream n beats starting at index first; toggle alternates s_valid 1/0
  task automatic send_beats(input int first, input int n, input bit toggle);
    int i;
    int guard;
    bit ph;
    bit x;
    i = 0; guard = 0; ph = 1'b1;
    while (i < n && guard < 4*n + 64) begin
      s_valid = toggle ? ph : 1'b1;
      s_data  = beat(first + i);
      @(negedge clk);
      x = s_ready && s_valid;
      @(posedge clk); #1;
      if (x) i++;
      ph = !ph;
      guard++;
    end
    s_valid = 1'b0;
    tests_run++;
    if (i != n) begin
      tests_failed++;
      $display("FAIL beat_stream: got %0d beats accepted, required %0d", i, n);
    end
  endtask

  task automatic wait_done(input string name, output int dc);
    int g;
    g = 0; dc = -1;
    while (g < 200) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
      g++;
    end
    tests_run++;
    if (dc < 0) begin
      tests_failed++;
      $display("FAIL %s: got no done within 200 cycles, required done pulse", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    tests_run += 6;
    if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_s_ready: got %b, required 0", s_ready); end
    if (weight_wr_en !== 1'b0) begin tests_failed++; $display("FAIL rst_wr_en: got %b, required 0", weight_wr_en); end
    if (weight_wr_addr !== '0) begin tests_failed++; $display("FAIL rst_wr_addr: got %h, required 0", weight_wr_addr); end
    if (weight_wr_data !== '0) begin tests_failed++; $display("FAIL rst_wr_data: got %h, required 0", weight_wr_data[63:0]); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %b, required 0", done); end
`ifdef MM_WLOAD_STALL_CNT_EN
    tests_run++;
    if (stall_cycles !== 16'd0) begin tests_failed++; $display("FAIL rst_stall: got %0d, required 0", stall_cycles); end
`endif
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int sc, dc, w0;
    w0 = wr_cnt;
    push_exp(13'h0100, 0);
    push_exp(13'h0101, 16);
    start_job(13'h0100, 13'd2, sc);
    send_beats(0, 32, 1'b0);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy: got %b, required 1", busy); end
    wait_done("b2b_done", dc);
    tests_run += 5;
    if (wr_cnt - w0 != 2) begin tests_failed++; $display("FAIL b2b_writes: got %0d, required 2", wr_cnt - w0); end
    if (last_wr_cyc != sc + 33) begin tests_failed++; $display("FAIL b2b_write_cycle: got %0d, required %0d", last_wr_cyc, sc + 33); end
    if (dc != last_wr_cyc + 1) begin tests_failed++; $display("FAIL b2b_done_cycle: got %0d, required %0d", dc, last_wr_cyc + 1); end
    if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_after_done: got done=%b busy=%b, required 0 0", done, busy); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL b2b_sb_empty: got %0d pending, required 0", exp_q.size()); end
`ifdef MM_WLOAD_STALL_CNT_EN
    tests_run++;
    if (stall_cycles !== 16'd0) begin tests_failed++; $display("FAIL b2b_stall: got %0d, required 0", stall_cycles); end
`endif
  endtask

  task automatic test_zero_rows();
    int sc, dc, w0, r0;
    w0 = wr_cnt; r0 = ready_cnt;
    start_job(13'h00AA, 13'd0, sc);
    wait_done("zero_done", dc);
    tests_run += 3;
    // start sampled in cycle sc-1, so done lands in the very next cycle
    if (dc != sc) begin tests_failed++; $display("FAIL zero_done_cycle: got %0d, required %0d", dc, sc); end
    if (ready_cnt != r0) begin tests_failed++; $display("FAIL zero_s_ready: got %0d ready cycles, required 0", ready_cnt - r0); end
    if (wr_cnt != w0) begin tests_failed++; $display("FAIL zero_writes: got %0d, required 0", wr_cnt - w0); end
  endtask

  task automatic test_wrap();
    int sc, dc, w0;
    w0 = wr_cnt;
    push_exp(13'h1FFF, 100);
    push_exp(13'h0000, 116);
    start_job(13'h1FFF, 13'd2, sc);
    send_beats(100, 32, 1'b0);
    wait_done("wrap_done", dc);
    tests_run += 2;
    if (wr_cnt - w0 != 2) begin tests_failed++; $display("FAIL wrap_writes: got %0d, required 2", wr_cnt - w0); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL wrap_sb_empty: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    int sc, dc, w0;
    w0 = wr_cnt;
    push_exp(13'h0050, 500);
    start_job(13'h0050, 13'd1, sc);
    send_beats(500, 16, 1'b1);
    wait_done("stall_done", dc);
    tests_run += 3;
    if (wr_cnt - w0 != 1) begin tests_failed++; $display("FAIL stall_writes: got %0d, required 1", wr_cnt - w0); end
    if (last_wr_cyc != sc + 31) begin tests_failed++; $display("FAIL stall_write_cycle: got %0d, required %0d", last_wr_cyc, sc + 31); end
    if (dc != sc + 32) begin tests_failed++; $display("FAIL stall_done_cycle: got %0d, required %0d", dc, sc + 32); end
`ifdef MM_WLOAD_STALL_CNT_EN
    tests_run++;
    if (stall_cycles !== 16'd15) begin tests_failed++; $display("FAIL stall_count: got %0d, required 15", stall_cycles); end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (stall_cycles !== 16'd15) begin tests_failed++; $display("FAIL stall_count_hold: got %0d, required 15", stall_cycles); end
`endif
  endtask

  task automatic test_reset_midload();
    int sc, dc, w0, d0;
    w0 = wr_cnt; d0 = done_cnt;
    start_job(13'h0200, 13'd1, sc);
    send_beats(200, 7, 1'b0);
    rstn = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_async: got busy=%b s_ready=%b, required 0 0", busy, s_ready);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run += 2;
    if (wr_cnt != w0) begin tests_failed++; $display("FAIL midrst_no_write: got %0d writes, required 0", wr_cnt - w0); end
    if (done_cnt != d0) begin tests_failed++; $display("FAIL midrst_no_done: got %0d dones, required 0", done_cnt - d0); end
    push_exp(13'h0300, 300);
    start_job(13'h0300, 13'd1, sc);
    send_beats(300, 16, 1'b0);
    wait_done("midrst_fresh_done", dc);
    tests_run += 2;
    if (wr_cnt - w0 != 1) begin tests_failed++; $display("FAIL midrst_fresh_writes: got %0d, required 1", wr_cnt - w0); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL midrst_sb_empty: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_start_ignored();
    int sc, dc, w0;
    w0 = wr_cnt;
    push_exp(13'h0400, 600);
    push_exp(13'h0401, 616);
    start_job(13'h0400, 13'd2, sc);
    send_beats(600, 5, 1'b0);
    // stray request mid-LOAD, alongside a one-cycle bubble
    start_valid       = 1'b1;
    weight_start_addr = 13'h0555;
    row_count         = 13'd7;
    @(posedge clk); #1;
    start_valid = 1'b0;
    send_beats(605, 27, 1'b0);
    wait_done("ign_done", dc);
    tests_run += 3;
    if (wr_cnt - w0 != 2) begin tests_failed++; $display("FAIL ign_writes: got %0d, required 2", wr_cnt - w0); end
    if (last_wr_cyc != sc + 34) begin tests_failed++; $display("FAIL ign_write_cycle: got %0d, required %0d", last_wr_cyc, sc + 34); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL ign_sb_empty: got %0d pending, required 0", exp_q.size()); end
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || wr_cnt - w0 != 2) begin
      tests_failed++;
      $display("FAIL ign_stays_idle: got busy=%b writes=%0d, required 0 2", busy, wr_cnt - w0);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_zero_rows();
    test_wrap();
    test_stall();
    test_reset_midload();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
